// File: rtl/types_pkg.sv
// Shared types for the instruction ROM: word/address types, the NOP word and
// the loader state enum.
package types_pkg;

  localparam int unsigned IROM_SIZE = 16;
  localparam int unsigned INSTR_W   = 32;

  typedef logic [INSTR_W-1:0]           i_t;
  typedef logic [$clog2(IROM_SIZE)-1:0] pc_t;

  localparam i_t NOP_INSTR = '0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } rom_state_e;

endpackage

// File: rtl/prog_rom.sv
// Loadable program ROM: a streamed load port fills the array, a combinational
// fetch port returns the instruction at pc plus its wrapped successor.
module prog_rom
  import types_pkg::*;
#(
  parameter int unsigned DEPTH = IROM_SIZE,
  parameter int unsigned IW    = $bits(i_t),
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic [AW-1:0] pc,
  output logic [IW-1:0] instr,
  output logic [AW-1:0] nxt_pc,
  input  logic          load_start,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [IW-1:0] ld_data,
  input  logic          ld_last,
  output logic          loaded,
  output logic [AW:0]   prog_len,
  output logic          err
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  rom_state_e    state, state_nxt;
  logic [AW:0]   wr_ptr, wr_ptr_nxt;
  logic [AW:0]   prog_len_nxt;
  logic          err_nxt;
  logic          mem_we;
  logic          accept;
  logic          overflow;
  logic [IW-1:0] mem [DEPTH];

  logic [AW:0]   pc_ext;
  logic [AW:0]   pc_inc;

  assign ld_ready = (state == LOAD) && !load_start;
  assign accept   = ld_ready && ld_valid;
  assign overflow = (wr_ptr == FULL);
  assign loaded   = (state == RUN);

  // Next-state logic; load_start takes priority over any beat in the same cycle.
  always_comb begin
    state_nxt    = state;
    wr_ptr_nxt   = wr_ptr;
    prog_len_nxt = prog_len;
    err_nxt      = err;
    mem_we       = 1'b0;
    if (load_start) begin
      state_nxt    = LOAD;
      wr_ptr_nxt   = '0;
      prog_len_nxt = '0;
      err_nxt      = 1'b0;
    end else if (accept) begin
      if (overflow) begin
        err_nxt = 1'b1;
      end else begin
        mem_we     = 1'b1;
        wr_ptr_nxt = wr_ptr + (AW+1)'(1);
      end
      if (ld_last) begin
        if (err || overflow) begin
          state_nxt    = EMPTY;
          prog_len_nxt = '0;
        end else begin
          state_nxt    = RUN;
          prog_len_nxt = wr_ptr + (AW+1)'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= EMPTY;
      wr_ptr   <= '0;
      prog_len <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      wr_ptr   <= wr_ptr_nxt;
      prog_len <= prog_len_nxt;
      err      <= err_nxt;
    end
  end

  // Reset clears every word so a stale program can never leak through.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mem <= '{default: '0};
    end else if (mem_we) begin
      mem[AW'(wr_ptr)] <= ld_data;
    end
  end

  assign pc_ext = (AW+1)'(pc);
  assign pc_inc = pc_ext + (AW+1)'(1);

  always_comb begin
    instr  = IW'(NOP_INSTR);
    nxt_pc = '0;
    if (loaded && (pc_ext < prog_len)) begin
      instr = mem[pc];
    end
    if (loaded && (pc_inc < prog_len)) begin
      nxt_pc = AW'(pc_inc);
    end
  end

endmodule

// File: tb/tb_prog_rom.sv
// Bench for prog_rom: directed scenarios then random load traffic, all
// checked against a queue-based model of the resident and pending programs.
module tb_prog_rom;
  import types_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned IW    = 32;
  localparam int unsigned AW    = 4;

  logic          CLK = 1'b0;
  logic          nRST;
  logic [AW-1:0] pc;
  logic [IW-1:0] instr;
  logic [AW-1:0] nxt_pc;
  logic          load_start;
  logic          ld_valid;
  logic          ld_ready;
  logic [IW-1:0] ld_data;
  logic          ld_last;
  logic          loaded;
  logic [AW:0]   prog_len;
  logic          err;

  int total = 0;
  int bad   = 0;

  // Model: words of the program being streamed in, and the resident program.
  logic [IW-1:0] pend[$];
  logic [IW-1:0] prog[$];
  bit            m_loading;
  bit            m_run;
  bit            m_err;

  prog_rom #(.DEPTH(DEPTH), .IW(IW), .AW(AW)) dut (
    .CLK(CLK), .nRST(nRST), .pc(pc), .instr(instr), .nxt_pc(nxt_pc),
    .load_start(load_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .loaded(loaded),
    .prog_len(prog_len), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    prog.delete();
    m_loading = 0;
    m_run     = 0;
    m_err     = 0;
  endtask

  task automatic model_edge(input bit ls, input bit v, input logic [IW-1:0] d, input bit last);
    if (ls) begin
      m_loading = 1;
      m_run     = 0;
      m_err     = 0;
      pend.delete();
      prog.delete();
    end else if (m_loading && v) begin
      if (pend.size() < DEPTH) pend.push_back(d);
      else m_err = 1;
      if (last) begin
        m_loading = 0;
        if (!m_err) begin
          prog  = pend;
          m_run = 1;
        end else begin
          prog.delete();
        end
      end
    end
  endtask

  task automatic probe(input int p);
    logic [IW-1:0] e_instr;
    int            e_nxt;
    pc = AW'(p);
    #1;
    e_instr = (m_run && p < prog.size()) ? prog[p] : '0;
    e_nxt   = (!m_run || p + 1 >= prog.size()) ? 0 : p + 1;
    chk("instr", 64'(instr), 64'(e_instr));
    chk("nxt_pc", 64'(nxt_pc), 64'(e_nxt));
  endtask

  task automatic check_state();
    chk("loaded", 64'(loaded), 64'(m_run));
    chk("prog_len", 64'(prog_len), 64'(prog.size()));
    chk("err", 64'(err), 64'(m_err));
  endtask

  // One clock: drive inputs, check ld_ready, take the edge, check results.
  task automatic cyc(input bit ls, input bit v, input logic [IW-1:0] d, input bit last);
    load_start = ls;
    ld_valid   = v;
    ld_data    = d;
    ld_last    = last;
    #1;
    chk("ld_ready", 64'(ld_ready), 64'(m_loading && !ls));
    @(posedge CLK);
    model_edge(ls, v, d, last);
    #1;
    load_start = 0;
    ld_valid   = 0;
    ld_last    = 0;
    check_state();
    probe(int'($urandom_range(0, DEPTH - 1)));
  endtask

  task automatic load_prog(input int n, input int base);
    cyc(1, 0, '0, 0);
    for (int i = 0; i < n; i++) cyc(0, 1, IW'(base + i), (i == n - 1));
  endtask

  initial begin
    nRST = 1'b0; pc = '0; load_start = 0; ld_valid = 0; ld_data = '0; ld_last = 0;
    model_reset();
    #12;
    probe(3);
    chk("rst_loaded", 64'(loaded), 64'(0));
    chk("rst_ld_ready", 64'(ld_ready), 64'(0));
    check_state();
    nRST = 1'b1;
    @(posedge CLK); #1;

    // Three-word program, then fetches inside and outside it.
    cyc(1, 0, '0, 0);
    cyc(0, 1, 32'hA, 0);
    cyc(0, 1, 32'hB, 0);
    cyc(0, 1, 32'hC, 1);
    chk("p3_loaded", 64'(loaded), 64'(1));
    chk("p3_len", 64'(prog_len), 64'(3));
    probe(2);
    chk("p3_instr2", 64'(instr), 64'hC);
    chk("p3_wrap", 64'(nxt_pc), 64'(0));
    probe(5);
    chk("p3_instr5", 64'(instr), 64'(0));

    // Restart from RUN drops the program immediately.
    cyc(1, 0, '0, 0);
    chk("restart_loaded", 64'(loaded), 64'(0));
    chk("restart_len", 64'(prog_len), 64'(0));
    probe(0);
    chk("restart_instr0", 64'(instr), 64'(0));

    // Full-depth program, then one beat too many.
    load_prog(DEPTH, 32'h100);
    chk("full_len", 64'(prog_len), 64'(DEPTH));
    chk("full_err", 64'(err), 64'(0));
    probe(DEPTH - 1);
    chk("full_last", 64'(instr), 64'(32'h100 + DEPTH - 1));
    load_prog(DEPTH + 1, 32'h200);
    chk("ovf_err", 64'(err), 64'(1));
    chk("ovf_loaded", 64'(loaded), 64'(0));

    // load_start wins over a concurrent beat, then a fresh two-word program.
    cyc(1, 0, '0, 0);
    cyc(0, 1, 32'h11, 0);
    cyc(0, 1, 32'h12, 0);
    cyc(1, 1, 32'h13, 0);
    cyc(0, 1, 32'h1, 0);
    cyc(0, 1, 32'h2, 1);
    chk("reload_len", 64'(prog_len), 64'(2));
    probe(0);
    chk("reload_mem0", 64'(instr), 64'h1);

    // Reset in the middle of a load.
    cyc(1, 0, '0, 0);
    cyc(0, 1, 32'h21, 0);
    cyc(0, 1, 32'h22, 0);
    nRST = 1'b0;
    model_reset();
    #1;
    chk("midrst_loaded", 64'(loaded), 64'(0));
    chk("midrst_ready", 64'(ld_ready), 64'(0));
    check_state();
    #2 nRST = 1'b1;
    @(posedge CLK); #1;
    cyc(0, 1, 32'h23, 0);
    cyc(0, 1, 32'h24, 1);
    chk("midrst_after", 64'(loaded), 64'(0));

    // Random traffic: restarts, gaps, short and overflowing programs.
    begin
      int last_div = 4;
      for (int n = 0; n < 600; n++) begin
        bit ls = ($urandom_range(0, 24) == 0);
        bit v  = ($urandom_range(0, 2) != 0);
        bit lt = ($urandom_range(0, last_div) == 0);
        if (ls) last_div = int'($urandom_range(1, 30));
        cyc(ls, v, IW'($urandom()), lt);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
